// File: rtl/jtdsp16_pkg.sv
// Shared definitions for the JTDSP16 hardware loop (DO/REDO) instruction cache.
package jtdsp16_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FILL   = 2'd1,
    ST_REPLAY = 2'd2
  } loop_state_e;

  // A DO with NI equal to this code replays the already stored body (REDO).
  localparam int unsigned NI_REDO = 0;

endpackage

// File: rtl/jtdsp16_loop_mem.sv
// Loop body storage: DEPTH x 16 words, synchronous write, combinational read.
module jtdsp16_loop_mem #(
  parameter int unsigned DEPTH = 15,
  parameter int unsigned AW    = 4
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [15:0]   i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [15:0]   o_rdata
);

  logic [15:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/jtdsp16_loop.sv
// JTDSP16 hardware loop controller: captures a DO body from ROM, then replays it
// from the local cache while holding the program counter.
module jtdsp16_loop
  import jtdsp16_pkg::*;
#(
  parameter int unsigned DEPTH = 15,
  parameter int unsigned KW    = 7,
  parameter int unsigned NIW   = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           cen,
  input  logic           do_start,
  input  logic [NIW-1:0] do_ni,
  input  logic [KW-1:0]  do_k,
  input  logic [15:0]    rom_dout,
  output logic [15:0]    cache_dout,
  output logic           use_cache,
  output logic           pc_hold,
  output logic           no_int,
  output logic           busy,
  output logic           err
);

  localparam int unsigned    PW       = $clog2(DEPTH);
  localparam logic [NIW-1:0] DEPTH_NI = NIW'(DEPTH);

  loop_state_e    r_state, w_state_nxt;
  logic [PW-1:0]  r_wr_ptr, r_rd_ptr;
  logic [NIW-1:0] r_ni, r_body_len;
  logic [KW-1:0]  r_rem;
  logic           r_err;

  logic           w_do_ok, w_redo_ok, w_wr_last, w_rd_last;
  logic           w_start_fill, w_start_redo, w_fill_step, w_replay_step, w_err_nxt;
  logic [15:0]    w_mem_rdata;

  assign w_do_ok   = (do_ni != NIW'(NI_REDO)) && (do_ni <= DEPTH_NI) && (do_k != '0);
  assign w_redo_ok = (do_ni == NIW'(NI_REDO)) && (r_body_len != '0) && (do_k != '0);
  assign w_wr_last = (NIW'(r_wr_ptr) == r_ni - NIW'(1));
  assign w_rd_last = (NIW'(r_rd_ptr) == r_body_len - NIW'(1));

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_start_fill  = 1'b0;
    w_start_redo  = 1'b0;
    w_fill_step   = 1'b0;
    w_replay_step = 1'b0;
    w_err_nxt     = 1'b0;
    if (cen) begin
      unique case (r_state)
        ST_IDLE: begin
          if (do_start) begin
            if (w_do_ok) begin
              w_start_fill = 1'b1;
              w_state_nxt  = ST_FILL;
            end else if (w_redo_ok) begin
              w_start_redo = 1'b1;
              w_state_nxt  = ST_REPLAY;
            end else begin
              w_err_nxt = 1'b1;
            end
          end
        end
        ST_FILL: begin
          w_err_nxt   = do_start;
          w_fill_step = 1'b1;
          if (w_wr_last) w_state_nxt = (r_rem == '0) ? ST_IDLE : ST_REPLAY;
        end
        ST_REPLAY: begin
          w_err_nxt     = do_start;
          w_replay_step = 1'b1;
          if (w_rd_last && r_rem == KW'(1)) w_state_nxt = ST_IDLE;
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // Pointers wrap to 0 on the last entry so they never reach DEPTH.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_rem      <= '0;
      r_body_len <= '0;
      r_ni       <= '0;
      r_err      <= 1'b0;
    end else begin
      r_err <= w_err_nxt;
      if (w_start_fill) begin
        r_ni     <= do_ni;
        r_rem    <= do_k - KW'(1);
        r_wr_ptr <= '0;
      end
      if (w_start_redo) begin
        r_rem    <= do_k;
        r_rd_ptr <= '0;
      end
      if (w_fill_step) begin
        if (w_wr_last) begin
          r_wr_ptr   <= '0;
          r_body_len <= r_ni;
          r_rd_ptr   <= '0;
        end else begin
          r_wr_ptr <= r_wr_ptr + PW'(1);
        end
      end
      if (w_replay_step) begin
        if (w_rd_last) begin
          r_rd_ptr <= '0;
          r_rem    <= r_rem - KW'(1);
        end else begin
          r_rd_ptr <= r_rd_ptr + PW'(1);
        end
      end
    end
  end

  jtdsp16_loop_mem #(
    .DEPTH (DEPTH),
    .AW    (PW)
  ) u_mem (
    .clk     (clk),
    .i_we    (w_fill_step),
    .i_waddr (r_wr_ptr),
    .i_wdata (rom_dout),
    .i_raddr (r_rd_ptr),
    .o_rdata (w_mem_rdata)
  );

  assign cache_dout = w_mem_rdata;
  assign use_cache  = (r_state == ST_REPLAY);
  assign pc_hold    = (r_state == ST_REPLAY);
  assign busy       = (r_state != ST_IDLE);
  assign no_int     = busy;
  assign err        = r_err;

endmodule

// File: doc/jtdsp16_loop.md
JTDSP16_LOOP -- requirements
Module: jtdsp16_loop

Interface
REQ-001 The block SHALL expose parameter DEPTH, default 15, meaning the maximum loop-body length in instructions (2..63).
REQ-002 The block SHALL expose parameter KW, default 7, meaning the iteration-count width.
REQ-003 The block SHALL expose parameter NIW, default 4, meaning the NI field width, with 2^NIW-1 >= DEPTH.
REQ-004 clk  in  1  system clock; one clock; all state changes on the rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 cen  in  1  clock enable; one instruction slot per cen-high cycle.
REQ-007 do_start  in  1  loop request, sampled when cen=1.
REQ-008 do_ni  in  NIW  body length NI; 0 means redo.
REQ-009 do_k  in  KW  iteration count K.
REQ-010 rom_dout  in  16  instruction fetched from ROM in the current slot.
REQ-011 cache_dout  out  16  replayed instruction.
REQ-012 use_cache  out  1  downstream decoder takes cache_dout instead of rom_dout.
REQ-013 pc_hold  out  1  program counter must not advance.
REQ-014 no_int  out  1  interrupts blocked.
REQ-015 busy  out  1  loop in progress (FILL or REPLAY).
REQ-016 err  out  1  one-cycle pulse on a rejected request.

Function
REQ-017 The block SHALL implement the states IDLE, FILL and REPLAY; it SHALL change state only on cycles where cen=1.
REQ-018 In IDLE, do_start with 1<=NI<=DEPTH and K>=1 SHALL latch NI, store K-1 as the remaining pass count, clear wr_ptr and enter FILL.
REQ-019 In FILL, each cen SHALL write rom_dout to mem[wr_ptr] and increment wr_ptr; use_cache=0 and pc_hold=0.
REQ-020 On the write of entry NI-1, the block SHALL record body_len=NI and enter IDLE if the remaining count is 0, or otherwise REPLAY with rd_ptr=0.
REQ-021 In REPLAY, cache_dout SHALL equal mem[rd_ptr] combinationally, use_cache=1 and pc_hold=1; each cen SHALL increment rd_ptr.
REQ-022 At the end of a REPLAY pass (rd_ptr=body_len-1 with cen=1), the block SHALL go to IDLE if remaining=1, otherwise decrement remaining and set rd_ptr=0.
REQ-023 In IDLE, do_start with NI=0 (redo), body_len!=0 and K>=1 SHALL set remaining=K and enter REPLAY directly at rd_ptr=0.
REQ-024 Redo with body_len=0, K=0, NI>DEPTH, or do_start while busy SHALL be ignored, leave the state unchanged and pulse err for one cycle.
REQ-025 NI=1 SHALL be legal; such a pass lasts exactly one cen slot.
REQ-026 no_int SHALL equal busy, and busy SHALL be 1 in FILL and REPLAY.
REQ-027 The stored body and body_len SHALL persist across IDLE for later redo; a new valid DO SHALL overwrite them.
REQ-028 With cen=0, all state, pointers and outputs SHALL hold.
REQ-029 Pointers SHALL never exceed DEPTH-1, and the remaining count SHALL never wrap below 0.

Reset
REQ-030 rst SHALL force IDLE, clear wr_ptr, rd_ptr, remaining and body_len, and drive use_cache, pc_hold, no_int, busy and err to 0 at the next clock edge, including mid-FILL or mid-REPLAY.
REQ-031 Memory contents SHALL NOT require reset, and cache_dout SHALL be don't-care while use_cache=0.
REQ-032 rst SHALL take priority over cen and do_start.

Structure
REQ-033 The state enumeration and the NI=0 redo code SHALL live in the shared package jtdsp16_pkg.
REQ-034 The body storage SHALL be the sub-module jtdsp16_loop_mem: DEPTH x 16, synchronous write, combinational read.
REQ-035 The state machine and counters SHALL remain in jtdsp16_loop.

Verification
REQ-036 DO NI=3 K=2 on words A,B,C -> FILL for 3 slots, then REPLAY outputs A,B,C with use_cache=1 and pc_hold=1, then IDLE.
REQ-037 DO NI=2 K=1 -> FILL for 2 slots, return to IDLE with no REPLAY and use_cache never set; then redo K=3 -> 6 slots replaying the same two words.
REQ-038 DO NI=4 K=3 with cen toggling 1,0 -> outputs frozen on cen=0 slots; exactly 8 REPLAY slots.
REQ-039 do_start during REPLAY, redo after reset, and NI=DEPTH+1 -> each gives a single err pulse with state unchanged.
REQ-040 rst asserted on the 2nd replayed slot -> next cycle shows IDLE with all outputs 0, and a following redo is rejected with err.
REQ-041 DEPTH=31, NIW=5: DO NI=31 K=2 -> 31 FILL slots plus 31 replay slots, and pointers never exceed 30.
